// File: rtl/life_display.sv
// life_display: life-count FSM with post-hit invulnerability, plus a heart-row overlay
// that addresses a 1-cycle icon ROM. Optional `define LIFE_BLINK_EN blinks hearts while hurt.
module life_display #(
  parameter int                    DATA_WIDTH  = 12,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    ICON_W      = 16,
  parameter int                    ICON_H      = 15,
  parameter int                    MAX_LIVES   = 5,
  parameter int                    INIT_LIVES  = 3,
  parameter int                    X0          = 8,
  parameter int                    Y0          = 8,
  parameter int                    GAP         = 4,
  parameter logic [DATA_WIDTH-1:0] TRANSP      = 12'h0F0,
  parameter int                    HURT_CYCLES = 50000000,
  parameter int                    BLINK_BIT   = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic                  video_on,
  input  logic                  lose_life,
  input  logic                  gain_life,
  input  logic                  restart,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] rgb_o,
  output logic                  hit_o,
  output logic [2:0]            lives_o,
  output logic                  game_over
);

  localparam int HCW = $clog2(HURT_CYCLES);
  localparam logic [HCW-1:0] HURT_LAST = HCW'(HURT_CYCLES - 1);
  localparam logic [HCW-1:0] HC_ONE    = HCW'(1'b1);

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HURT = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [2:0]           lives_r, lives_s;
  logic [HCW-1:0]       hurt_cnt_r, hurt_cnt_s;
  logic                 game_over_r;
  logic                 blank_s;
  logic                 y_ok_s;
  logic [9:0]           dy_s;
  logic [MAX_LIVES-1:0] in_k_s;
  logic                 in_any_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic                 v1_r;
  logic                 opaque_s;

  function automatic logic [9:0] icon_x(input int k);
    return 10'(X0 + k * (ICON_W + GAP));
  endfunction

`ifdef LIFE_BLINK_EN
  logic [BLINK_BIT:0] blink_cnt_r;

  // Blink counter: restarts on HURT entry, free-runs while hurt.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_r <= '0;
    end else if (state_s == ST_HURT && state_r != ST_HURT) begin
      blink_cnt_r <= '0;
    end else if (state_r == ST_HURT) begin
      blink_cnt_r <= blink_cnt_r + {{BLINK_BIT{1'b0}}, 1'b1};
    end else begin
      blink_cnt_r <= blink_cnt_r;
    end
  end

  assign blank_s = (state_r == ST_HURT) && blink_cnt_r[BLINK_BIT];
`else
  assign blank_s = 1'b0;
`endif

  // Life FSM next-state: restart wins, simultaneous loss+gain cancel out.
  always_comb begin
    state_s    = state_r;
    lives_s    = lives_r;
    hurt_cnt_s = hurt_cnt_r;
    if (restart) begin
      state_s    = ST_PLAY;
      lives_s    = 3'(INIT_LIVES);
      hurt_cnt_s = '0;
    end else begin
      case (state_r)
        ST_PLAY: begin
          if (lose_life && !gain_life) begin
            hurt_cnt_s = '0;
            if (lives_r <= 3'd1) begin
              lives_s = 3'd0;
              state_s = ST_OVER;
            end else begin
              lives_s = lives_r - 3'd1;
              state_s = ST_HURT;
            end
          end else if (gain_life && !lose_life && lives_r < 3'(MAX_LIVES)) begin
            lives_s = lives_r + 3'd1;
          end else begin
            lives_s = lives_r;
          end
        end
        ST_HURT: begin
          if (gain_life && !lose_life && lives_r < 3'(MAX_LIVES)) begin
            lives_s = lives_r + 3'd1;
          end else begin
            lives_s = lives_r;
          end
          if (hurt_cnt_r == HURT_LAST) begin
            state_s    = ST_PLAY;
            hurt_cnt_s = '0;
          end else begin
            hurt_cnt_s = hurt_cnt_r + HC_ONE;
          end
        end
        ST_OVER: begin
          lives_s = 3'd0;
        end
        default: begin
          state_s    = ST_PLAY;
          lives_s    = 3'(INIT_LIVES);
          hurt_cnt_s = '0;
        end
      endcase
    end
  end

  // Life FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_PLAY;
      lives_r     <= 3'(INIT_LIVES);
      hurt_cnt_r  <= '0;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      lives_r     <= lives_s;
      hurt_cnt_r  <= hurt_cnt_s;
      game_over_r <= (state_s == ST_OVER);
    end
  end

  assign lives_o   = lives_r;
  assign game_over = game_over_r;

  assign y_ok_s = (pixel_y >= 10'(Y0)) && (pixel_y < 10'(Y0 + ICON_H));
  assign dy_s   = pixel_y - 10'(Y0);

  // Stage 0: one window compare per icon slot; icons never overlap so at most one hits.
  always_comb begin
    in_k_s = '0;
    addr_s = rom_addr;
    for (int k = 0; k < MAX_LIVES; k++) begin
      in_k_s[k] = video_on && !blank_s && y_ok_s &&
                  (pixel_x >= icon_x(k)) && (pixel_x < icon_x(k) + 10'(ICON_W)) &&
                  (3'(k) < lives_r);
      addr_s = in_k_s[k] ? ADDR_WIDTH'(dy_s * 10'(ICON_W) + (pixel_x - icon_x(k))) : addr_s;
    end
  end

  assign in_any_s = |in_k_s;
  assign opaque_s = v1_r && (rom_data != TRANSP);

  // Stages 1 and 2: ROM address/valid, then colour-keyed overlay output.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
      v1_r     <= 1'b0;
      hit_o    <= 1'b0;
      rgb_o    <= '0;
    end else begin
      rom_addr <= addr_s;
      v1_r     <= in_any_s;
      hit_o    <= opaque_s;
      rgb_o    <= opaque_s ? rom_data : '0;
    end
  end

endmodule

// File: tb/tb_life_display.sv
// Bench for life_display: directed scenarios then random stimulus, every cycle compared
// against an arithmetic model of the life rules and the 2-clk overlay pipeline.
module tb_life_display;

  localparam int HC     = 10;
  localparam int BB     = 2;
  localparam logic [11:0] TRANSP = 12'h0F0;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, lose_life, gain_life, restart;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data;
  logic [11:0] rgb_o;
  logic        hit_o;
  logic [2:0]  lives_o;
  logic        game_over;

  always #5 clk = ~clk;

  life_display #(.HURT_CYCLES(HC), .BLINK_BIT(BB)) dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .lose_life(lose_life), .gain_life(gain_life),
    .restart(restart), .rom_addr(rom_addr), .rom_data(rom_data),
    .rgb_o(rgb_o), .hit_o(hit_o), .lives_o(lives_o), .game_over(game_over)
  );

  int checks = 0;
  int failures = 0;
  logic [11:0] rom [256];

  // reference model state (mode: 0 play, 1 hurt, 2 over)
  int          m_lives, m_mode, m_hc;
  logic [7:0]  m_addr;
  logic        m_v1, m_hit;
  logic [11:0] m_rgb;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int x, y, dx, k;
    bit in;
    if (reset) begin
      m_lives = 3; m_mode = 0; m_hc = 0;
      m_addr = 8'h00; m_v1 = 1'b0; m_hit = 1'b0; m_rgb = 12'h000;
    end else begin
      m_hit = m_v1 && (rom_data != TRANSP);
      m_rgb = m_hit ? rom_data : 12'h000;
      x = int'(pixel_x); y = int'(pixel_y);
      in = 1'b0;
      dx = x - 8;
      k  = (dx >= 0) ? dx / 20 : 0;
      if (video_on && y >= 8 && y < 8 + 15 && dx >= 0 && (dx % 20) < 16 && k < m_lives)
        in = 1'b1;
`ifdef LIFE_BLINK_EN
      if (m_mode == 1 && ((m_hc >> BB) & 1) == 1) in = 1'b0;
`endif
      if (in) m_addr = 8'((y - 8) * 16 + (dx % 20));
      m_v1 = in;
      if (restart) begin
        m_lives = 3; m_mode = 0; m_hc = 0;
      end else if (m_mode == 0) begin
        if (lose_life && !gain_life) begin
          m_lives = m_lives - 1;
          m_mode  = (m_lives == 0) ? 2 : 1;
          m_hc    = 0;
        end else if (gain_life && !lose_life && m_lives < 5) begin
          m_lives = m_lives + 1;
        end
      end else if (m_mode == 1) begin
        if (gain_life && !lose_life && m_lives < 5) m_lives = m_lives + 1;
        if (m_hc == HC - 1) begin
          m_mode = 0; m_hc = 0;
        end else begin
          m_hc = m_hc + 1;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    rom_data = rom[m_addr];
    check_eq("rom_addr", rom_addr, m_addr);
    check_eq("hit_o", hit_o, m_hit);
    check_eq("rgb_o", rgb_o, m_rgb);
    check_eq("lives_o", lives_o, m_lives);
    check_eq("game_over", game_over, (m_mode == 2));
    lose_life = 1'b0; gain_life = 1'b0; restart = 1'b0; reset = 1'b0;
  endtask

  task automatic set_pix(input int x, input int y, input bit von);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = von;
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? TRANSP : 12'($urandom);
    rom[8'h23] = 12'hF00;
    rom[8'h00] = TRANSP;
    rom[8'h22] = 12'h00F;
    rom_data = 12'h000;
    lose_life = 1'b0; gain_life = 1'b0; restart = 1'b0;
    set_pix(0, 0, 1'b0);

    // reset state
    reset = 1'b1;
    step();
    check_eq("reset_lives", lives_o, 3'd3);
    check_eq("reset_hit", hit_o, 1'b0);
    check_eq("reset_addr", rom_addr, 8'h00);

    // icon 1 pixel, opaque red
    set_pix(31, 10, 1'b1);
    step();
    check_eq("addr_31_10", rom_addr, 8'h23);
    set_pix(0, 0, 1'b0);
    step();
    check_eq("hit_31_10", hit_o, 1'b1);
    check_eq("rgb_31_10", rgb_o, 12'hF00);

    // icon 3 absent with three lives
    set_pix(71, 10, 1'b1);
    step(); step();
    check_eq("hit_absent", hit_o, 1'b0);
    check_eq("rgb_absent", rgb_o, 12'h000);

    // transparent key
    set_pix(8, 8, 1'b1);
    step();
    check_eq("addr_8_8", rom_addr, 8'h00);
    step();
    check_eq("hit_transp", hit_o, 1'b0);

    // hurt window: second loss ignored, loss counts again once back in PLAY
    set_pix(10, 10, 1'b1);
    lose_life = 1'b1; step();
    check_eq("lose1", lives_o, 3'd2);
    step(); step();
    check_eq("hurt_hit", hit_o, 1'b1);
    lose_life = 1'b1; step();
    check_eq("lose_in_hurt", lives_o, 3'd2);
    for (int i = 0; i < 7; i++) step();
    lose_life = 1'b1; step();
    check_eq("lose_after_hurt", lives_o, 3'd1);

    // saturation and simultaneous events
    restart = 1'b1; step();
    check_eq("restart_lives", lives_o, 3'd3);
    for (int i = 0; i < 4; i++) begin
      gain_life = 1'b1; step();
    end
    check_eq("saturate", lives_o, 3'd5);
    lose_life = 1'b1; gain_life = 1'b1; step();
    check_eq("lose_gain", lives_o, 3'd5);

    // lose everything
    for (int n = 0; n < 5; n++) begin
      lose_life = 1'b1; step();
      for (int i = 0; i < HC + 1; i++) step();
    end
    check_eq("over_flag", game_over, 1'b1);
    check_eq("over_lives", lives_o, 3'd0);
    gain_life = 1'b1; step();
    check_eq("over_gain", lives_o, 3'd0);
    step();
    check_eq("over_no_icon", hit_o, 1'b0);
    restart = 1'b1; step();
    check_eq("restart_over_lives", lives_o, 3'd3);
    check_eq("restart_over_flag", game_over, 1'b0);

    // mid-frame reset drops the pipeline
    set_pix(31, 10, 1'b1);
    step();
    reset = 1'b1; step();
    check_eq("reset_mid_hit", hit_o, 1'b0);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 4) == 0)
        set_pix($urandom_range(0, 639), $urandom_range(0, 479), 1'b1);
      else
        set_pix($urandom_range(0, 130), $urandom_range(0, 30), ($urandom_range(0, 7) != 0));
      lose_life = ($urandom_range(0, 39) == 0);
      gain_life = ($urandom_range(0, 49) == 0);
      restart   = ($urandom_range(0, 299) == 0);
      reset     = ($urandom_range(0, 999) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
